// File: rtl/oitf_param_if.sv
// Bundle of the dispatch, writeback-retire and source-query signals of the
// outstanding-instruction tracking FIFO.
//
// Handshake: an allocation happens on a rising clock edge exactly when
// dis_ena (valid) and dis_ready (ready) are both high; dis_ena may be held
// while dis_ready is low and nothing is taken. A retire happens when ret_ena
// is high and the FIFO is not empty. flush overrides both in its cycle.
//
// master: the pipeline side (dispatch/writeback), slave: the tracker.
interface oitf_param_if #(
  parameter int DEPTH  = 4,
  parameter int RA_W   = 5,
  parameter int NUM_RS = 2
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                     dis_ena;
  logic                     dis_rdwen;
  logic [RA_W-1:0]          dis_rdidx;
  logic                     dis_ready;
  logic [PTR_W-1:0]         dis_ptr;
  logic                     dis_waw;
  logic                     ret_ena;
  logic [PTR_W-1:0]         ret_ptr;
  logic [RA_W-1:0]          ret_rdidx;
  logic                     flush;
  logic [NUM_RS-1:0]        rs_en;
  logic [NUM_RS*RA_W-1:0]   rs_idx;
  logic [NUM_RS-1:0]        rs_match;
  logic                     oitf_empty;
  logic                     oitf_full;
  logic [PTR_W:0]           oitf_cnt;

  modport master (
    output dis_ena, dis_rdwen, dis_rdidx, ret_ena, flush, rs_en, rs_idx,
    input  dis_ready, dis_ptr, dis_waw, ret_ptr, ret_rdidx, rs_match,
           oitf_empty, oitf_full, oitf_cnt
  );

  modport slave (
    input  dis_ena, dis_rdwen, dis_rdidx, ret_ena, flush, rs_en, rs_idx,
    output dis_ready, dis_ptr, dis_waw, ret_ptr, ret_rdidx, rs_match,
           oitf_empty, oitf_full, oitf_cnt
  );
endinterface

// File: rtl/oitf_param.sv
// Outstanding-instruction tracking FIFO: in-order allocate at dispatch,
// in-order retire at writeback, RAW hazard lookup on NUM_RS source ports
// and WAW lookup on the dispatching destination.
//
// Optional feature macro: OITF_RET_BYPASS_EN
//   defined   - the head entry retiring this cycle is hidden from rs_match
//               and dis_waw, so a consumer can dispatch in the writeback cycle
//               (adds a combinational path ret_ena -> rs_match/dis_waw).
//   undefined - the retiring entry still hits in its retire cycle.
module oitf_param #(
  parameter int DEPTH  = 4,
  parameter int RA_W   = 5,
  parameter int NUM_RS = 2
) (
  input logic           clk,
  input logic           rst,
  oitf_param_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]    alc_ptr;
  logic [PTR_W:0]    ret_ptr;
  logic [DEPTH-1:0]  vld;
  logic [RA_W-1:0]   rdidx_q [DEPTH];

  logic [PTR_W-1:0]  alc_idx;
  logic [PTR_W-1:0]  ret_idx;
  logic              full;
  logic              empty;
  logic              alc_fire;
  logic              ret_fire;
  logic [DEPTH-1:0]  ret_mask;
  logic [DEPTH-1:0]  live;
  logic [RA_W-1:0]   rs_k;
  logic [NUM_RS-1:0] rs_match_c;
  logic              dis_waw_c;

  assign alc_idx  = alc_ptr[PTR_W-1:0];
  assign ret_idx  = ret_ptr[PTR_W-1:0];
  assign full     = (alc_ptr[PTR_W] != ret_ptr[PTR_W]) && (alc_idx == ret_idx);
  assign empty    = (alc_ptr == ret_ptr);
  // No pass-through: a full FIFO refuses allocation even if the head retires now.
  assign alc_fire = bus.dis_ena && !full;
  assign ret_fire = bus.ret_ena && !empty;

  // Pointer and valid-bit state; reset beats flush, flush beats alloc/retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      alc_ptr <= '0;
      ret_ptr <= '0;
      vld     <= '0;
    end else if (bus.flush) begin
      ret_ptr <= alc_ptr;
      vld     <= '0;
    end else begin
      // Retire and alloc never address the same slot in one cycle: that
      // would need the FIFO to be both empty and full.
      if (ret_fire) begin
        vld[ret_idx] <= 1'b0;
        ret_ptr      <= ret_ptr + 1'b1;
      end
      if (alc_fire) begin
        // r0 and non-writing instructions occupy a slot but never hazard.
        vld[alc_idx] <= bus.dis_rdwen && (bus.dis_rdidx != '0);
        alc_ptr      <= alc_ptr + 1'b1;
      end
    end
  end

  // Destination payload is not reset; it is only meaningful while its slot is live.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && alc_fire) begin
      rdidx_q[alc_idx] <= bus.dis_rdidx;
    end
  end

  // Entries visible to hazard lookup, optionally hiding the retiring head.
  always_comb begin
    ret_mask = '0;
`ifdef OITF_RET_BYPASS_EN
    if (ret_fire && !bus.flush) ret_mask[ret_idx] = 1'b1;
`endif
    live = vld & ~ret_mask;
  end

  // RAW lookup per source port and WAW lookup on the dispatching destination.
  always_comb begin
    rs_match_c = '0;
    dis_waw_c  = 1'b0;
    rs_k       = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      rs_k = bus.rs_idx[k*RA_W +: RA_W];
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.rs_en[k] && (rs_k != '0) && live[i] && (rdidx_q[i] == rs_k)) begin
          rs_match_c[k] = 1'b1;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.dis_rdwen && (bus.dis_rdidx != '0) && live[i] &&
          (rdidx_q[i] == bus.dis_rdidx)) begin
        dis_waw_c = 1'b1;
      end
    end
  end

  assign bus.dis_ready  = !full;
  assign bus.dis_ptr    = alc_idx;
  assign bus.dis_waw    = dis_waw_c;
  assign bus.ret_ptr    = ret_idx;
  assign bus.ret_rdidx  = rdidx_q[ret_idx];
  assign bus.rs_match   = rs_match_c;
  assign bus.oitf_empty = empty;
  assign bus.oitf_full  = full;
  assign bus.oitf_cnt   = alc_ptr - ret_ptr;
endmodule

// File: tb/tb_oitf_param.sv
// Directed bench for oitf_param with DEPTH=4, RA_W=5, NUM_RS=2.
module tb_oitf_param;
  localparam int DEPTH  = 4;
  localparam int RA_W   = 5;
  localparam int NUM_RS = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   n_fail;
  int   exp_alc;
  int   exp_ret;
  logic [RA_W-1:0] exp_q[$];
  logic [RA_W-1:0] head;

  oitf_param_if #(.DEPTH(DEPTH), .RA_W(RA_W), .NUM_RS(NUM_RS)) bus ();

  oitf_param #(.DEPTH(DEPTH), .RA_W(RA_W), .NUM_RS(NUM_RS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic wen, input logic [RA_W-1:0] rd);
    bus.dis_ena   = 1'b1;
    bus.dis_rdwen = wen;
    bus.dis_rdidx = rd;
    tick();
    bus.dis_ena   = 1'b0;
    exp_alc++;
  endtask

  task automatic retire();
    bus.ret_ena = 1'b1;
    tick();
    bus.ret_ena = 1'b0;
    exp_ret++;
  endtask

  task automatic query(input logic [1:0] en, input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    bus.rs_en  = en;
    bus.rs_idx = {b, a};
    settle();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    exp_alc = 0; exp_ret = 0;
    bus.dis_ena = 1'b0; bus.dis_rdwen = 1'b0; bus.dis_rdidx = '0;
    bus.ret_ena = 1'b0; bus.flush = 1'b0; bus.rs_en = '0; bus.rs_idx = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    query(2'b11, 5'd5, 5'd6);
    bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd5; settle();
    check("rst_empty", bus.oitf_empty, 1);
    check("rst_full", bus.oitf_full, 0);
    check("rst_ready", bus.dis_ready, 1);
    check("rst_dis_ptr", bus.dis_ptr, 0);
    check("rst_ret_ptr", bus.ret_ptr, 0);
    check("rst_cnt", bus.oitf_cnt, 0);
    check("rst_match", bus.rs_match, 0);
    check("rst_waw", bus.dis_waw, 0);

    // 1: fill with 5,6,7,8; fifth allocation refused.
    alloc(1, 5'd5); alloc(1, 5'd6); alloc(1, 5'd7); alloc(1, 5'd8);
    check("t1_full", bus.oitf_full, 1);
    check("t1_cnt", bus.oitf_cnt, 4);
    check("t1_ready", bus.dis_ready, 0);
    check("t1_dis_ptr", bus.dis_ptr, 0);
    query(2'b11, 5'd7, 5'd9);
    check("t1_match_7_9", bus.rs_match, 2'b01);
    bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd8; settle();
    check("t1_waw_8", bus.dis_waw, 1);
    alloc(1, 5'd9); exp_alc--;
    check("t1_refused_cnt", bus.oitf_cnt, 4);
    check("t1_refused_ptr", bus.dis_ptr, 0);
    query(2'b10, 5'd0, 5'd9);
    check("t1_refused_match", bus.rs_match, 2'b00);
    check("t1_head_5", bus.ret_rdidx, 5'd5); retire();
    check("t1_head_6", bus.ret_rdidx, 5'd6); retire();
    check("t1_head_7", bus.ret_rdidx, 5'd7); retire();
    check("t1_head_8", bus.ret_rdidx, 5'd8); retire();
    check("t1_drained", bus.oitf_empty, 1);
    check("t1_ret_ptr", bus.ret_ptr, 0);

    // 2: allocated entry is visible only from the next cycle.
    bus.rs_en = 2'b01; bus.rs_idx = {5'd0, 5'd3};
    bus.dis_ena = 1'b1; bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd3; settle();
    check("t2_match_alloc_cycle", bus.rs_match, 2'b00);
    tick(); bus.dis_ena = 1'b0; exp_alc++; settle();
    check("t2_match_next", bus.rs_match, 2'b01);
    check("t2_waw_3", bus.dis_waw, 1);
    bus.ret_ena = 1'b1; settle();
`ifdef OITF_RET_BYPASS_EN
    check("t2_match_ret_cycle", bus.rs_match, 2'b00);
`else
    check("t2_match_ret_cycle", bus.rs_match, 2'b01);
`endif
    tick(); bus.ret_ena = 1'b0; exp_ret++; settle();
    check("t2_match_after_ret", bus.rs_match, 2'b00);
    check("t2_empty", bus.oitf_empty, 1);

    // 3: r0 and non-writing entries occupy slots but never hazard.
    alloc(1, 5'd0); alloc(0, 5'd9); alloc(1, 5'd4);
    check("t3_cnt", bus.oitf_cnt, 3);
    query(2'b11, 5'd0, 5'd9);
    check("t3_match_0_9", bus.rs_match, 2'b00);
    bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd9; settle();
    check("t3_waw_9", bus.dis_waw, 0);
    bus.dis_rdidx = 5'd0; settle();
    check("t3_waw_0", bus.dis_waw, 0);
    bus.dis_rdidx = 5'd4; settle();
    check("t3_waw_4", bus.dis_waw, 1);
    check("t3_head_0", bus.ret_rdidx, 5'd0); retire();
    check("t3_head_9", bus.ret_rdidx, 5'd9); retire();
    check("t3_head_4", bus.ret_rdidx, 5'd4); retire();
    check("t3_empty", bus.oitf_empty, 1);

    // 4: ten simultaneous alloc/retire pairs at occupancy 2.
    alloc(1, 5'd10); exp_q.push_back(5'd10);
    alloc(1, 5'd11); exp_q.push_back(5'd11);
    for (int i = 0; i < 10; i++) begin
      check("t4_ret_ptr", bus.ret_ptr, exp_ret % DEPTH);
      check("t4_head", bus.ret_rdidx, exp_q[0]);
      bus.dis_ena = 1'b1; bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'(12 + i);
      bus.ret_ena = 1'b1;
      tick();
      bus.dis_ena = 1'b0; bus.ret_ena = 1'b0;
      head = exp_q.pop_front();
      exp_q.push_back(5'(12 + i));
      exp_alc++; exp_ret++;
      check("t4_cnt", bus.oitf_cnt, 2);
    end
    check("t4_head_last0", bus.ret_rdidx, exp_q[0]); retire();
    check("t4_head_last1", bus.ret_rdidx, exp_q[1]); retire();
    exp_q.delete();
    check("t4_empty", bus.oitf_empty, 1);
    check("t4_ret_ptr_end", bus.ret_ptr, exp_ret % DEPTH);

    // 5: full + retire + alloc refuses the alloc; retire on empty is ignored.
    alloc(1, 5'd1); alloc(1, 5'd2); alloc(1, 5'd3); alloc(1, 5'd4);
    check("t5_full", bus.oitf_full, 1);
    bus.dis_ena = 1'b1; bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd20; bus.ret_ena = 1'b1;
    tick();
    bus.dis_ena = 1'b0; bus.ret_ena = 1'b0; exp_ret++;
    check("t5_cnt3", bus.oitf_cnt, 3);
    check("t5_dis_ptr", bus.dis_ptr, exp_alc % DEPTH);
    check("t5_head_2", bus.ret_rdidx, 5'd2);
    query(2'b01, 5'd20, 5'd0);
    check("t5_no_20", bus.rs_match, 2'b00);
    retire(); retire(); retire();
    check("t5_empty", bus.oitf_empty, 1);
    bus.ret_ena = 1'b1; tick(); bus.ret_ena = 1'b0;
    check("t5_empty_ret_empty", bus.oitf_empty, 1);
    check("t5_empty_ret_cnt", bus.oitf_cnt, 0);
    check("t5_empty_ret_ptr", bus.ret_ptr, exp_ret % DEPTH);
    bus.dis_ena = 1'b1; bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd21; bus.ret_ena = 1'b1;
    tick();
    bus.dis_ena = 1'b0; bus.ret_ena = 1'b0; exp_alc++;
    check("t5_alloc_only_cnt", bus.oitf_cnt, 1);
    check("t5_alloc_only_head", bus.ret_rdidx, 5'd21);
    retire();

    // 6: flush with a pending allocation, then reset mid-traffic.
    alloc(1, 5'd5); alloc(1, 5'd6); alloc(1, 5'd7);
    check("t6_cnt3", bus.oitf_cnt, 3);
    bus.flush = 1'b1; bus.dis_ena = 1'b1; bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd9;
    tick();
    bus.flush = 1'b0; bus.dis_ena = 1'b0;
    check("t6_flush_empty", bus.oitf_empty, 1);
    check("t6_flush_cnt", bus.oitf_cnt, 0);
    check("t6_flush_dis_ptr", bus.dis_ptr, exp_alc % DEPTH);
    check("t6_flush_ret_ptr", bus.ret_ptr, exp_alc % DEPTH);
    query(2'b11, 5'd5, 5'd9);
    check("t6_flush_match", bus.rs_match, 2'b00);
    alloc(1, 5'd12); alloc(1, 5'd13);
    rst = 1'b1; bus.flush = 1'b1; tick(); rst = 1'b0; bus.flush = 1'b0;
    query(2'b11, 5'd12, 5'd13);
    check("t6_rst_empty", bus.oitf_empty, 1);
    check("t6_rst_cnt", bus.oitf_cnt, 0);
    check("t6_rst_dis_ptr", bus.dis_ptr, 0);
    check("t6_rst_ret_ptr", bus.ret_ptr, 0);
    check("t6_rst_match", bus.rs_match, 2'b00);
    check("t6_rst_ready", bus.dis_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
